// File: rtl/mmap_arb_pkg.sv
// Shared types and defaults for the mmap round-robin arbiter.
package mmap_arb_pkg;

    // Arbiter FSM states: waiting for a request, transfer in flight, completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Read data returned to a master whose transfer was aborted by the watchdog.
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmap_rr_arbiter_rr_pick.sv
// Combinational one-hot round-robin selector.
// Picks the first set request bit searching upward from ptr+1, wrapping around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0]   base;
    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] dbl_gnt;
    int unsigned          nxt;

    // Doubled request vector: subtracting the one-hot start position isolates the
    // lowest request at or above it; the upper copy supplies the wrap-around case.
    always_comb begin
        nxt = 32'(ptr) + 32'd1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            base[i] = (i == nxt);
        end
        dbl_req = {req, req};
        dbl_gnt = dbl_req & ~(dbl_req - {{NUM_REQ{1'b0}}, base});
        grant   = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/mmap_rr_arbiter.sv
// Round-robin arbiter sharing one mmap valid/ready port between NUM_REQ masters,
// with one transfer in flight and a watchdog that aborts hung transfers.
module mmap_rr_arbiter
    import mmap_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = DEFAULT_ERR_RDATA
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*4-1:0] req_wstrb_i,
    output logic [31:0]          req_rdata_o,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 mst_valid_o,
    output logic [31:0]          mst_addr_o,
    output logic [31:0]          mst_wdata_o,
    output logic [3:0]           mst_wstrb_o,
    input  logic [31:0]          mst_rdata_i,
    input  logic                 mst_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 timeout_o
);

    localparam int unsigned     PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e          state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win_idx;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_REQ-1:0]  pick;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [3:0]          sel_wstrb;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (pick)
    );

    // Route the winning master's payload and encode its index for the pointer.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_addr  = req_addr_i[32*i +: 32];
                sel_wdata = req_wdata_i[32*i +: 32];
                sel_wstrb = req_wstrb_i[4*i +: 4];
                win_idx   = PTR_W'(i);
            end
        end
    end

    // Arbitration FSM with payload latch, watchdog and registered responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= PTR_RST;
            cnt         <= '0;
            grant_o     <= '0;
            mst_valid_o <= 1'b0;
            mst_addr_o  <= '0;
            mst_wdata_o <= '0;
            mst_wstrb_o <= '0;
            req_rdata_o <= '0;
            req_ready_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            req_ready_o <= '0;
            timeout_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        mst_addr_o  <= sel_addr;
                        mst_wdata_o <= sel_wdata;
                        mst_wstrb_o <= sel_wstrb;
                        grant_o     <= pick;
                        ptr         <= win_idx;
                        cnt         <= '0;
                        mst_valid_o <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Bridge completion takes priority over a watchdog expiring on the same cycle.
                    if (mst_ready_i) begin
                        req_rdata_o <= mst_rdata_i;
                        req_ready_o <= grant_o;
                        mst_valid_o <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        req_rdata_o <= ERR_RDATA;
                        req_ready_o <= grant_o;
                        timeout_o   <= 1'b1;
                        mst_valid_o <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: begin
                    grant_o     <= '0;
                    mst_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmap_rr_arbiter.sv
// Self-checking bench for mmap_rr_arbiter: master/bridge stimulus, a transaction-level
// arbitration model and a scoreboard monitor checking every completion.
module tb_mmap_rr_arbiter;

    localparam int unsigned NR  = 2;
    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct { int lat; logic [31:0] rdata; int late; } plan_t;
    typedef struct { int mst; logic [31:0] rdata; bit to; int cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } txn_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR*4-1:0]  req_wstrb;
    logic [31:0]      req_rdata;
    logic [NR-1:0]    req_ready;
    logic             mst_valid;
    logic [31:0]      mst_addr;
    logic [31:0]      mst_wdata;
    logic [3:0]       mst_wstrb;
    logic [31:0]      mst_rdata;
    logic             mst_ready;
    logic [NR-1:0]    grant;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_win = NR - 1;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    txn_t  mq[NR][$];

    logic [NR-1:0]    snap_valid = '0;
    logic [NR*32-1:0] snap_addr  = '0;
    logic [NR*32-1:0] snap_wdata = '0;
    logic [NR*4-1:0]  snap_wstrb = '0;

    mmap_rr_arbiter #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO),
        .ERR_RDATA   (ERR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .req_rdata_o (req_rdata),
        .req_ready_o (req_ready),
        .mst_valid_o (mst_valid),
        .mst_addr_o  (mst_addr),
        .mst_wdata_o (mst_wdata),
        .mst_wstrb_o (mst_wstrb),
        .mst_rdata_i (mst_rdata),
        .mst_ready_i (mst_ready),
        .grant_o     (grant),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    // Cycle counter and the request inputs as seen at each rising edge.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        snap_valid <= req_valid;
        snap_addr  <= req_addr;
        snap_wdata <= req_wdata;
        snap_wstrb <= req_wstrb;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bridge model plus arbitration reference: on each new transfer, predict the winner
    // from the requests present at the arbitration edge, then answer per the plan.
    initial begin : bridge
        plan_t       cur;
        exp_t        e;
        int          e_mst;
        int          idx;
        int          age;
        int          late_wait;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        prev_mv;
        prev_mv   = 1'b0;
        late_wait = 0;
        age       = 0;
        e_mst     = 0;
        cur       = '{lat: 0, rdata: 32'h0, late: 0};
        mst_ready = 1'b0;
        mst_rdata = '0;
        forever begin
            @(negedge clk);
            mst_ready = 1'b0;
            if (rst) begin
                prev_mv   = 1'b0;
                late_wait = 0;
                last_win  = NR - 1;
            end else begin
                if (mst_valid && !prev_mv) begin
                    e_mst = -1;
                    for (int k = 1; k <= NR; k++) begin
                        idx = (last_win + k) % NR;
                        if (e_mst < 0 && snap_valid[idx]) e_mst = idx;
                    end
                    if (e_mst < 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_mst_valid: got 1 expected 0 (t=%0t)", $time);
                        e_mst = 0;
                    end
                    last_win = e_mst;
                    e_addr   = snap_addr[32*e_mst +: 32];
                    e_wdata  = snap_wdata[32*e_mst +: 32];
                    e_wstrb  = snap_wstrb[4*e_mst +: 4];
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                    end else begin
                        cur.lat   = ($urandom_range(0, 7) == 0) ? int'(TO) + 2 : int'($urandom_range(0, 3));
                        cur.rdata = $urandom;
                        cur.late  = int'($urandom_range(0, 2));
                    end
                    e.mst   = e_mst;
                    e.to    = (cur.lat >= int'(TO));
                    e.rdata = e.to ? ERR : cur.rdata;
                    e.cyc   = cyc + ((cur.lat + 1 < int'(TO)) ? cur.lat + 1 : int'(TO));
                    exp_q.push_back(e);
                    age = 0;
                    check("grant_winner", grant, 32'(1) << e_mst);
                end
                if (mst_valid) begin
                    check("mst_addr", mst_addr, e_addr);
                    check("mst_wdata", mst_wdata, e_wdata);
                    check("mst_wstrb", mst_wstrb, e_wstrb);
                    if (age == cur.lat) begin
                        mst_ready = 1'b1;
                        mst_rdata = cur.rdata;
                    end
                    age++;
                end else begin
                    if (prev_mv && cur.lat >= int'(TO)) late_wait = cur.late;
                    if (late_wait == 1) begin
                        mst_ready = 1'b1;
                        mst_rdata = $urandom;
                    end
                    if (late_wait > 0) late_wait--;
                end
                prev_mv = mst_valid;
            end
        end
    end

    // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_ready", req_ready, '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ready_master", req_ready, 32'(1) << e.mst);
                        check("ready_rdata", req_rdata, e.rdata);
                        check("ready_timeout", timeout, e.to);
                        check("ready_cycle", cyc, e.cyc);
                    end
                end else begin
                    check("stray_timeout", timeout, 1'b0);
                end
            end
        end
    end

    task automatic wait_ready(input int m, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready[m] && k < budget);
        if (!req_ready[m]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready_m%0d: got no ready expected ready within %0d cycles", m, budget);
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || mst_valid || req_ready != '0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_txn(output txn_t t);
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endtask

    // Drives all masters from their queues; a master drops or replaces its request after its ready.
    task automatic run_masters(input int max_gap, input int budget);
        bit   active[NR];
        int   gap[NR];
        int   k;
        bit   busy;
        txn_t t;
        for (int m = 0; m < NR; m++) begin
            active[m] = 1'b0;
            gap[m]    = 0;
        end
        k = 0;
        forever begin
            for (int m = 0; m < NR; m++) begin
                if (active[m] && req_ready[m]) begin
                    active[m]    = 1'b0;
                    req_valid[m] = 1'b0;
                    gap[m]       = int'($urandom_range(0, max_gap));
                end
                if (!active[m]) begin
                    if (gap[m] > 0) begin
                        gap[m]--;
                    end else if (mq[m].size() > 0) begin
                        t = mq[m].pop_front();
                        req_addr[32*m +: 32]  = t.addr;
                        req_wdata[32*m +: 32] = t.wdata;
                        req_wstrb[4*m +: 4]   = t.wstrb;
                        req_valid[m]          = 1'b1;
                        active[m]             = 1'b1;
                    end
                end
            end
            busy = 1'b0;
            for (int m = 0; m < NR; m++) busy |= active[m] || (mq[m].size() > 0);
            if (!busy) break;
            if (k >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_masters_budget: got busy after %0d cycles expected done", k);
                break;
            end
            @(negedge clk);
            k++;
        end
        req_valid = '0;
    endtask

    initial begin : stimulus
        txn_t t;
        int   k;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mst_valid", mst_valid, 1'b0);
        check("rst_grant", grant, '0);
        check("rst_req_ready", req_ready, '0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_req_rdata", req_rdata, '0);
        check("rst_mst_addr", mst_addr, '0);
        check("rst_mst_wdata", mst_wdata, '0);
        check("rst_mst_wstrb", mst_wstrb, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read from master 0
        plan_q.push_back('{lat: 1, rdata: 32'h1234_5678, late: 0});
        req_addr[31:0]  = 32'h1000_0004;
        req_wdata[31:0] = $urandom;
        req_wstrb[3:0]  = 4'h0;
        req_valid[0]    = 1'b1;
        @(negedge clk);
        check("single_mst_valid", mst_valid, 1'b1);
        check("single_grant", grant, 2'b01);
        wait_ready(0, 20);
        check("single_ready", req_ready, 2'b01);
        check("single_rdata", req_rdata, 32'h1234_5678);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("single_ready_one_cycle", req_ready, '0);
        drain(20);

        // Contention: both masters request continuously
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < NR; m++) begin
                rand_txn(t);
                mq[m].push_back(t);
            end
        end
        run_masters(0, 300);
        drain(40);

        // Write payload stays latched while the requester changes its data
        plan_q.push_back('{lat: 4, rdata: 32'h0BAD_0BAD, late: 0});
        req_addr[63:32]  = 32'h1000_1000;
        req_wdata[63:32] = 32'hCAFE_F00D;
        req_wstrb[7:4]   = 4'hF;
        req_valid[1]     = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mst_valid && k < 20);
        while (!req_ready[1] && k < 40) begin
            check("stable_wdata", mst_wdata, 32'hCAFE_F00D);
            check("stable_addr", mst_addr, 32'h1000_1000);
            req_wdata[63:32] = $urandom;
            @(negedge clk);
            k++;
        end
        check("stable_ready", req_ready, 2'b10);
        req_valid[1] = 1'b0;
        drain(20);

        // Timeout with a late bridge ready in the following IDLE cycle
        plan_q.push_back('{lat: int'(TO) + 5, rdata: 32'h1111_2222, late: 2});
        req_addr[31:0] = 32'h2000_0000;
        req_wstrb[3:0] = 4'h0;
        req_valid[0]   = 1'b1;
        wait_ready(0, 30);
        check("timeout_pulse", timeout, 1'b1);
        check("timeout_rdata", req_rdata, ERR);
        req_valid[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_ready_ignored", req_ready, '0);
            check("late_timeout_low", timeout, 1'b0);
        end
        drain(20);

        // Race: bridge ready lands on the last watchdog cycle
        plan_q.push_back('{lat: int'(TO) - 1, rdata: 32'hA5A5_5A5A, late: 0});
        req_addr[63:32] = 32'h3000_0008;
        req_wstrb[7:4]  = 4'h0;
        req_valid[1]    = 1'b1;
        wait_ready(1, 30);
        check("race_no_timeout", timeout, 1'b0);
        check("race_rdata", req_rdata, 32'hA5A5_5A5A);
        req_valid[1] = 1'b0;
        drain(20);

        // Randomized traffic with random gaps, latencies, timeouts and late readies
        for (int i = 0; i < 15; i++) begin
            for (int m = 0; m < NR; m++) begin
                rand_txn(t);
                mq[m].push_back(t);
            end
        end
        run_masters(3, 2000);
        drain(60);

        // Asynchronous reset in the middle of a transfer
        plan_q.push_back('{lat: 100, rdata: 32'h0, late: 0});
        req_addr[31:0] = $urandom;
        req_valid[0]   = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mst_valid && k < 10);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mst_valid", mst_valid, 1'b0);
        check("midrst_grant", grant, '0);
        check("midrst_req_ready", req_ready, '0);
        exp_q.delete();
        plan_q.delete();
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // After reset both request together and master 0 must win first
        for (int m = 0; m < NR; m++) begin
            rand_txn(t);
            mq[m].push_back(t);
        end
        plan_q.push_back('{lat: 0, rdata: 32'h5555_0000, late: 0});
        plan_q.push_back('{lat: 0, rdata: 32'h5555_0001, late: 0});
        run_masters(0, 100);
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "simulation time limit reached");
    end

endmodule
